// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_pkg
// Purpose  : Shared state encoding and width helper for the bit-serial
//            subtractor.
// Revision : 1.0 - initial release
// ============================================================================
package serial_subtractor_pkg;

    // Control states; encoding 2'd3 is unused and steers back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit-counter width: ceil(log2(v)), never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : full_subtractor
// Purpose  : One-bit full subtractor cell, d = a - b - bi with borrow out.
// Revision : 1.0 - initial release
// ============================================================================
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    // Difference bit is the parity of the three inputs.
    assign d  = a ^ b ^ bi;
    // Borrow when b exceeds a, or when a == b and a borrow is pending.
    assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial N-bit subtractor D = A - B - bi, LSB first, one bit
//            per clock, with valid/ready handshakes on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         bi,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] D,
    output logic         bo,
    output logic         ov
);

    localparam int          CW   = clog2_min1(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t         state;
    state_t         state_nxt;
    logic [N-1:0]   a_sr;
    logic [N-1:0]   b_sr;
    logic [N-1:0]   d_sr;
    logic           br;
    logic           a_msb;
    logic           b_msb;
    logic [CW-1:0]  cnt;
    logic           bo_r;
    logic           ov_r;
    logic           cell_d;
    logic           cell_bo;
    logic           accept;
    logic           last_bit;

    // Single shared cell works on the current LSBs and the pending borrow.
    full_subtractor u_cell (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .bi (br),
        .d  (cell_d),
        .bo (cell_bo)
    );

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign last_bit  = (state == ST_RUN) && (cnt == LAST);
    assign D         = d_sr;
    assign bo        = bo_r;
    assign ov        = ov_r;

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: load, N serial steps, then hold until consumed.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid)  state_nxt = ST_RUN;
            ST_RUN:  if (last_bit)  state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: operand capture on acceptance, one bit shifted per RUN edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            d_sr  <= '0;
            br    <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            cnt   <= '0;
            bo_r  <= 1'b0;
            ov_r  <= 1'b0;
        end else if (accept) begin
            a_sr  <= A;
            b_sr  <= B;
            br    <= bi;
            a_msb <= A[N-1];
            b_msb <= B[N-1];
            cnt   <= '0;
        end else if (state == ST_RUN) begin
            // Shift form keeps N == 1 legal (no empty part-selects).
            d_sr <= (d_sr >> 1) | (N'(cell_d) << (N - 1));
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            br   <= cell_bo;
            if (last_bit) begin
                cnt  <= '0;
                bo_r <= cell_bo;
                // Overflow: operand signs differ and result sign differs from A.
                ov_r <= (a_msb != b_msb) && (cell_d != a_msb);
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Self-checking bench for serial_subtractor (N = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         bi;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] D;
    logic         bo;
    logic         ov;

    int n_cmp  = 0;
    int n_fail = 0;

    serial_subtractor #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .bi        (bi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .bo        (bo),
        .ov        (ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer arithmetic on the unsigned and signed views.
    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                         output logic [N-1:0] d, output logic bout, output logic vout);
        int u;
        int s;
        u    = int'(a) - int'(b) - int'(c);
        s    = int'($signed(a)) - int'($signed(b)) - int'(c);
        d    = u[N-1:0];
        bout = (u < 0);
        vout = (s < -(2 ** (N - 1))) || (s > (2 ** (N - 1)) - 1);
    endtask

    // One full transaction with optional backpressure; a new in_valid is held
    // high during the stall to confirm it is not taken early.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                          input int stall, input string tag);
        logic [N-1:0] ed;
        logic         eb;
        logic         ev;
        int           edges;
        model(a, b, c, ed, eb, ev);
        @(negedge clk);
        A = a; B = b; bi = c; in_valid = 1'b1; out_ready = 1'b0;
        chk({tag, ":in_ready_idle"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = N'($urandom); B = N'($urandom); bi = 1'($urandom);
        chk({tag, ":in_ready_run"}, 32'(in_ready), 32'd0);
        edges = 0;
        while (!out_valid && edges < N + 4) begin
            @(posedge clk); #1;
            edges++;
        end
        chk({tag, ":latency"}, 32'(edges), 32'(N));
        chk({tag, ":D"},  32'(D),  32'(ed));
        chk({tag, ":bo"}, 32'(bo), 32'(eb));
        chk({tag, ":ov"}, 32'(ov), 32'(ev));
        if (stall > 0) in_valid = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk({tag, ":hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ":hold_rdy"},   32'(in_ready),  32'd0);
            chk({tag, ":hold_D"},     32'({D, bo, ov}), 32'({ed, eb, ev}));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({tag, ":released"}, 32'({out_valid, in_ready}), 32'b01);
    endtask

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        int           seen;

        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        A = 8'd77; B = 8'd3; bi = 1'b1;

        // Reset held with a request pending: nothing may be accepted.
        repeat (3) @(posedge clk);
        #1;
        chk("rst:in_ready",  32'(in_ready),  32'd1);
        chk("rst:out_valid", 32'(out_valid), 32'd0);
        chk("rst:outs",      32'({D, bo, ov}), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // Directed cases from the test plan.
        run_op(8'd100, 8'd58, 1'b0, 0, "sub100_58");
        run_op(8'd5,   8'd10, 1'b0, 0, "sub5_10");
        run_op(8'd0,   8'd0,  1'b1, 0, "sub0_0_bi");
        run_op(8'h80,  8'h01, 1'b0, 0, "ovf80_01");
        run_op(8'h7F,  8'hFF, 1'b0, 0, "ovf7F_FF");
        run_op(8'hC3,  8'h2A, 1'b1, 5, "bp5");
        run_op(8'h11,  8'h22, 1'b0, 0, "after_bp");

        // Mid-operation reset on the third RUN cycle.
        @(negedge clk);
        A = 8'd9; B = 8'd4; bi = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst:in_ready",  32'(in_ready),  32'd1);
        chk("midrst:out_valid", 32'(out_valid), 32'd0);
        chk("midrst:D",         32'(D),         32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (N + 3) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("midrst:no_result", 32'(seen), 32'd0);
        chk("midrst:idle",      32'(in_ready), 32'd1);
        run_op(8'd200, 8'd55, 1'b0, 0, "post_rst");

        // Random operands, borrow-in and backpressure.
        for (int k = 0; k < 24; k++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
